// File: rtl/mc_main_ctrl_if.sv
// Control bundle between the multicycle main FSM and the MIPS datapath/ALU controller.
// master = controller side, slave = datapath side.
interface mc_main_ctrl_if;
    logic [5:0] instr_op_i;
    logic [5:0] funct_i;
    logic       mem_ready_i;
    logic [3:0] ALUOp_o;
    logic       pc_write_o;
    logic       pc_write_cond_o;
    logic [1:0] pc_source_o;
    logic       i_or_d_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       ir_write_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       reg_write_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [3:0] state_o;
    logic       illegal_o;

    modport master (
        input  instr_op_i, funct_i, mem_ready_i,
        output ALUOp_o, pc_write_o, pc_write_cond_o, pc_source_o, i_or_d_o,
               mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
               reg_write_o, alu_src_a_o, alu_src_b_o, state_o, illegal_o
    );

    modport slave (
        output instr_op_i, funct_i, mem_ready_i,
        input  ALUOp_o, pc_write_o, pc_write_cond_o, pc_source_o, i_or_d_o,
               mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
               reg_write_o, alu_src_a_o, alu_src_b_o, state_o, illegal_o
    );
endinterface

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Latency: controls registered on entry to each state; ir_write/pc_write fire in the ready FETCH cycle.
// Backpressure: FETCH/MEMRD/MEMWR hold their request until mem_ready_i; EXEC_R held MUL_CYCLES for MUL.
module mc_main_ctrl #(
    parameter int MUL_CYCLES = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mc_main_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC_R = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_EXEC_I = 4'd10,
        S_IWB    = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGT   = 6'b000111;
    localparam logic [5:0] OP_BGE   = 6'b000001;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_MUL   = 6'b011000;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    ctrl_t      ctrl_q;
    logic [3:0] mul_cnt;
    logic       illegal_q;
    logic       op_legal;

    always_comb begin
        op_legal = 1'b1;
        case (bus.instr_op_i)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BGT, OP_BGE,
            OP_ADDI, OP_ORI, OP_J: op_legal = 1'b1;
            default:               op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  if (bus.mem_ready_i) state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.instr_op_i)
                    OP_RTYPE:                       state_nxt = S_EXEC_R;
                    OP_LW, OP_SW:                   state_nxt = S_MEMADR;
                    OP_BEQ, OP_BNE, OP_BGT, OP_BGE: state_nxt = S_BRANCH;
                    OP_ADDI, OP_ORI:                state_nxt = S_EXEC_I;
                    OP_J:                           state_nxt = S_JUMP;
                    default:                        state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = (bus.instr_op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready_i) state_nxt = S_MEMWB;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  if (bus.mem_ready_i) state_nxt = S_FETCH;
            S_EXEC_R: if (mul_cnt == 4'd0) state_nxt = S_RWB;
            S_RWB:    state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            S_EXEC_I: state_nxt = S_IWB;
            S_IWB:    state_nxt = S_FETCH;
            S_JUMP:   state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Control word for the state about to be entered, so outputs come straight from flops.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 4'b0010;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.alu_op    = 4'b0010;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                case (op)
                    OP_BNE:  c.alu_op = 4'b1010;
                    OP_BGT:  c.alu_op = 4'b1011;
                    OP_BGE:  c.alu_op = 4'b1001;
                    default: c.alu_op = 4'b0001;
                endcase
            end
            S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = (op == OP_ORI) ? 4'b0101 : 4'b0100;
            end
            S_IWB: begin
                c.reg_write = 1'b1;
                c.alu_op    = (op == OP_ORI) ? 4'b0101 : 4'b0100;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= S_IDLE;
            ctrl_q    <= '0;
            mul_cnt   <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            ctrl_q <= ctrl_for(state_nxt, bus.instr_op_i);
            // Non-MUL R-types load 0 so EXEC_R exits after a single cycle.
            if (state == S_DECODE)
                mul_cnt <= (bus.funct_i == FN_MUL) ? MUL_LOAD : 4'd0;
            else if (state == S_EXEC_R && mul_cnt != 4'd0)
                mul_cnt <= mul_cnt - 4'd1;
            if (state == S_DECODE && !op_legal)
                illegal_q <= 1'b1;
        end
    end

    assign bus.ir_write_o      = (state == S_FETCH) && bus.mem_ready_i;
    assign bus.pc_write_o      = ctrl_q.pc_write | ((state == S_FETCH) && bus.mem_ready_i);
    assign bus.pc_write_cond_o = ctrl_q.pc_write_cond;
    assign bus.pc_source_o     = ctrl_q.pc_source;
    assign bus.i_or_d_o        = ctrl_q.i_or_d;
    assign bus.mem_read_o      = ctrl_q.mem_read;
    assign bus.mem_write_o     = ctrl_q.mem_write;
    assign bus.reg_dst_o       = ctrl_q.reg_dst;
    assign bus.mem_to_reg_o    = ctrl_q.mem_to_reg;
    assign bus.reg_write_o     = ctrl_q.reg_write;
    assign bus.alu_src_a_o     = ctrl_q.alu_src_a;
    assign bus.alu_src_b_o     = ctrl_q.alu_src_b;
    assign bus.ALUOp_o         = ctrl_q.alu_op;
    assign bus.state_o         = state;
    assign bus.illegal_o       = illegal_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Bench for mc_main_ctrl: directed instruction table, randomized instruction stream
// against a trace-building reference model, and an asynchronous reset during MEMWR.
module tb_mc_main_ctrl;

    localparam int MULC = 4;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
    } ctl_t;

    typedef struct {
        int st;
        bit rdy;
    } step_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        int         fs;
        int         ms;
        int         exp_body;
        int         exp_pcw;
        logic [3:0] exp_alu;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mc_main_ctrl_if bus ();

    mc_main_ctrl #(.MUL_CYCLES(MULC)) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
    );

    ctl_t act;
    always_comb act = {bus.pc_write_o, bus.pc_write_cond_o, bus.pc_source_o, bus.i_or_d_o,
                       bus.mem_read_o, bus.mem_write_o, bus.ir_write_o, bus.reg_dst_o,
                       bus.mem_to_reg_o, bus.reg_write_o, bus.alu_src_a_o, bus.alu_src_b_o,
                       bus.ALUOp_o};

    int     checks = 0;
    int     errors = 0;
    step_t  q[$];
    int     fetch_cnt, body_cnt, irw_cnt, pcw_cnt;
    logic [3:0] last_alu;
    bit     model_ill = 1'b0;
    vec_t   vecs[12];

    task automatic chk(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, a, e);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h07, 6'h01, 6'h08, 6'h0D, 6'h02};
    endfunction

    // Expected control word from the per-state output table of the controller.
    function automatic ctl_t exp_ctl(input int st, input bit rdy, input logic [5:0] op);
        ctl_t e;
        e = '0;
        case (st)
            1: begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
            2: e.alu_src_b = 2'b11;
            3: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            4: begin e.mem_read = 1; e.i_or_d = 1; end
            5: begin e.reg_write = 1; e.mem_to_reg = 1; end
            6: begin e.mem_write = 1; e.i_or_d = 1; end
            7: begin e.alu_src_a = 1; e.alu_op = 4'b0010; end
            8: begin e.reg_write = 1; e.reg_dst = 1; e.alu_op = 4'b0010; end
            9: begin
                e.alu_src_a = 1; e.pc_write_cond = 1; e.pc_source = 2'b01;
                e.alu_op = (op == 6'h05) ? 4'b1010 : (op == 6'h07) ? 4'b1011 :
                           (op == 6'h01) ? 4'b1001 : 4'b0001;
            end
            10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = (op == 6'h0D) ? 4'b0101 : 4'b0100; end
            11: begin e.reg_write = 1; e.alu_op = (op == 6'h0D) ? 4'b0101 : 4'b0100; end
            12: begin e.pc_write = 1; e.pc_source = 2'b10; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic bit rnd_bit();
        return bit'($urandom_range(0, 1));
    endfunction

    // Expected per-cycle state trace of one instruction, FETCH through its last state.
    task automatic build(input logic [5:0] op, input logic [5:0] funct, input int fs, input int ms);
        q.delete();
        repeat (fs) q.push_back('{1, 1'b0});
        q.push_back('{1, 1'b1});
        q.push_back('{2, rnd_bit()});
        case (op)
            6'h00: begin
                repeat ((funct == 6'h18) ? MULC : 1) q.push_back('{7, rnd_bit()});
                q.push_back('{8, rnd_bit()});
            end
            6'h23: begin
                q.push_back('{3, rnd_bit()});
                repeat (ms) q.push_back('{4, 1'b0});
                q.push_back('{4, 1'b1});
                q.push_back('{5, rnd_bit()});
            end
            6'h2B: begin
                q.push_back('{3, rnd_bit()});
                repeat (ms) q.push_back('{6, 1'b0});
                q.push_back('{6, 1'b1});
            end
            6'h04, 6'h05, 6'h07, 6'h01: q.push_back('{9, rnd_bit()});
            6'h08, 6'h0D: begin
                q.push_back('{10, rnd_bit()});
                q.push_back('{11, rnd_bit()});
            end
            6'h02: q.push_back('{12, rnd_bit()});
            default: model_ill = 1'b1;
        endcase
    endtask

    // Entered at posedge+1; drives each step, checks, then clocks. n<0 runs the whole trace.
    task automatic run_trace(input logic [5:0] op, input int n);
        int lim;
        lim = (n < 0) ? q.size() : n;
        fetch_cnt = 0; body_cnt = 0; irw_cnt = 0; pcw_cnt = 0; last_alu = 4'd0;
        for (int i = 0; i < lim; i++) begin
            bus.mem_ready_i = q[i].rdy;
            #1;
            chk($sformatf("state[%0d] op%0h", i, op), int'(bus.state_o), q[i].st);
            chk($sformatf("ctrl[%0d] st%0d op%0h", i, q[i].st, op), int'(act),
                int'(exp_ctl(q[i].st, q[i].rdy, op)));
            if (bus.state_o == 4'd1) fetch_cnt++; else body_cnt++;
            if (bus.ir_write_o) irw_cnt++;
            if (bus.pc_write_o) pcw_cnt++;
            if (bus.ALUOp_o != 4'd0) last_alu = bus.ALUOp_o;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vecs[0]  = '{6'h00, 6'h20, 0, 0, 3, 1, 4'b0010};
        vecs[1]  = '{6'h23, 6'h00, 3, 3, 7, 1, 4'b0000};
        vecs[2]  = '{6'h00, 6'h18, 0, 0, 6, 1, 4'b0010};
        vecs[3]  = '{6'h05, 6'h00, 0, 0, 2, 1, 4'b1010};
        vecs[4]  = '{6'h07, 6'h00, 1, 0, 2, 1, 4'b1011};
        vecs[5]  = '{6'h01, 6'h00, 0, 0, 2, 1, 4'b1001};
        vecs[6]  = '{6'h04, 6'h00, 0, 0, 2, 1, 4'b0001};
        vecs[7]  = '{6'h08, 6'h00, 0, 0, 3, 1, 4'b0100};
        vecs[8]  = '{6'h0D, 6'h00, 2, 0, 3, 1, 4'b0101};
        vecs[9]  = '{6'h02, 6'h00, 0, 0, 2, 2, 4'b0000};
        vecs[10] = '{6'h2B, 6'h00, 0, 2, 5, 1, 4'b0000};
        vecs[11] = '{6'h3F, 6'h00, 0, 0, 1, 1, 4'b0000};

        rst_n = 1'b0;
        bus.mem_ready_i = 1'b1;
        bus.instr_op_i  = 6'h00;
        bus.funct_i     = 6'h20;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", int'(bus.state_o), 0);
        chk("reset ctrl", int'(act), 0);
        chk("reset illegal", int'(bus.illegal_o), 0);
        rst_n = 1'b1;
        #1;
        chk("idle after release", int'(bus.state_o), 0);
        chk("idle ctrl", int'(act), 0);
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            bus.instr_op_i = vecs[k].op;
            bus.funct_i    = vecs[k].funct;
            build(vecs[k].op, vecs[k].funct, vecs[k].fs, vecs[k].ms);
            run_trace(vecs[k].op, -1);
            chk($sformatf("vec%0d fetch cycles", k), fetch_cnt, vecs[k].fs + 1);
            chk($sformatf("vec%0d body cycles", k), body_cnt, vecs[k].exp_body);
            chk($sformatf("vec%0d ir_write pulses", k), irw_cnt, 1);
            chk($sformatf("vec%0d pc_write pulses", k), pcw_cnt, vecs[k].exp_pcw);
            chk($sformatf("vec%0d ALUOp", k), int'(last_alu), int'(vecs[k].exp_alu));
            chk($sformatf("vec%0d illegal", k), int'(bus.illegal_o), int'(model_ill));
            chk($sformatf("vec%0d back to fetch", k), int'(bus.state_o), 1);
        end

        for (int r = 0; r < 40; r++) begin
            logic [5:0] op, fn;
            logic [5:0] legal_ops [11];
            int idx;
            legal_ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h07, 6'h01, 6'h08, 6'h0D, 6'h02};
            idx = $urandom_range(0, 11);
            op  = (idx == 11) ? 6'($urandom) : legal_ops[idx];
            fn  = ($urandom_range(0, 1) == 1) ? 6'h18 : 6'($urandom);
            bus.instr_op_i = op;
            bus.funct_i    = fn;
            build(op, fn, $urandom_range(0, 3), $urandom_range(0, 3));
            run_trace(op, -1);
            chk($sformatf("rnd%0d illegal op%0h", r, op), int'(bus.illegal_o), int'(model_ill));
            chk($sformatf("rnd%0d legal flag op%0h", r, op), int'(is_legal(op) || model_ill), 1);
        end

        // Reset while a store waits on memory.
        bus.instr_op_i = 6'h2B;
        bus.funct_i    = 6'h00;
        build(6'h2B, 6'h00, 0, 5);
        run_trace(6'h2B, 3);
        bus.mem_ready_i = 1'b0;
        #1;
        chk("memwr entered", int'(bus.state_o), 6);
        chk("memwr request", int'(bus.mem_write_o), 1);
        rst_n = 1'b0;
        #1;
        chk("async rst mem_write", int'(bus.mem_write_o), 0);
        chk("async rst state", int'(bus.state_o), 0);
        chk("async rst ctrl", int'(act), 0);
        chk("async rst illegal", int'(bus.illegal_o), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("fetch after release", int'(bus.state_o), 1);
        chk("fetch mem_read", int'(bus.mem_read_o), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
